// File: rtl/io_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// Package gc: global constants shared by the URISC peripheral/memory blocks.
//
// Contents used by the IO memory arbiter:
//   WORD_SIZE        data/address width of the memory port
//   IO_COUNT         number of peripheral requesters sharing the port
//   VGA_I / PS2_I    requester indices
//   IO_IN / IO_OUT   transfer direction relative to memory
//                    (IO_IN = write into memory, IO_OUT = read from memory)
//   VGA_MEM_OFFSET   physical base added to VGA virtual addresses
//   KEYBOARD_ADD     physical base added to PS2 virtual addresses
//   IO_ARB_TIMEOUT   default ack timeout (IO_ARB_TIMEOUT_EN builds only)
//   IO_ARB_STATE     arbiter FSM state type
//   io_phys_addr()   virtual-to-physical translation, modulo 2^WORD_SIZE
// -----------------------------------------------------------------------------
package gc;

    localparam int WORD_SIZE = 64;
    localparam int IO_COUNT  = 2;

    localparam int VGA_I = 0;
    localparam int PS2_I = 1;

    localparam logic IO_IN  = 1'b1;
    localparam logic IO_OUT = 1'b0;

    localparam logic [WORD_SIZE-1:0] VGA_MEM_OFFSET = 64'h0000_0000_0000_0081;
    localparam logic [WORD_SIZE-1:0] KEYBOARD_ADD   = 64'h0000_0000_0000_0000;

    localparam int IO_ARB_TIMEOUT = 16;

    localparam int IO_IDX_W = (IO_COUNT > 1) ? $clog2(IO_COUNT) : 1;
    typedef logic [IO_IDX_W-1:0] io_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } IO_ARB_STATE;

    // Carry out of the top bit is discarded, so addresses near the top of the
    // range wrap around.
    function automatic logic [WORD_SIZE-1:0] io_phys_addr(
        input io_idx_t                idx,
        input logic [WORD_SIZE-1:0]   vaddr
    );
        if (idx == io_idx_t'(VGA_I))
            return vaddr + VGA_MEM_OFFSET;
        return vaddr + KEYBOARD_ADD;
    endfunction

endpackage

// File: rtl/io_mem_arbiter_picker.sv
// -----------------------------------------------------------------------------
// io_rr_picker: combinational two-way round-robin select.
//
// Ports:
//   req         in   IO_COUNT   per-requester request
//   last_grant  in   io_idx_t   index served by the previous transaction
//   winner      out  io_idx_t   selected requester (meaningful when valid)
//   valid       out  1          at least one requester is asking
//
// A lone requester always wins; on a tie the requester that was not served
// last wins, so neither side can be granted twice in a row under contention.
// -----------------------------------------------------------------------------
module io_rr_picker
    import gc::*;
(
    input  logic [IO_COUNT-1:0] req,
    input  io_idx_t             last_grant,
    output io_idx_t             winner,
    output logic                valid
);

    // NOTE: every output of a combinational block gets a default before any
    // branch so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        valid  = |req;
        winner = io_idx_t'(VGA_I);
        if (req[VGA_I] && req[PS2_I]) begin
            winner = (last_grant == io_idx_t'(VGA_I)) ? io_idx_t'(PS2_I)
                                                      : io_idx_t'(VGA_I);
        end else if (req[PS2_I]) begin
            winner = io_idx_t'(PS2_I);
        end
    end

endmodule

// File: rtl/io_mem_arbiter.sv
// -----------------------------------------------------------------------------
// io_mem_arbiter: shares the single data-memory port between the VGA and PS2
// peripheral controllers, one transaction at a time, granting round-robin.
//
// Parameters:
//   TIMEOUT     cycles to wait in WAIT for mem_ack before aborting
//               (only used when the macro IO_ARB_TIMEOUT_EN is defined)
//
// Optional build macro:
//   IO_ARB_TIMEOUT_EN  adds a WAIT-cycle counter; on expiry the transaction is
//                      aborted with an io_err pulse instead of io_done.
//                      Without it io_err is tied 0 and WAIT waits forever.
//
// Ports:
//   clk        in   1                    system clock
//   reset      in   1                    synchronous, active-high reset
//   io_req     in   IO_COUNT             request, held until io_done
//   io_dir     in   IO_COUNT             IO_IN = write memory, IO_OUT = read
//   io_addr    in   IO_COUNT*WORD_SIZE   virtual address, slice i = requester i
//   io_wdata   in   IO_COUNT*WORD_SIZE   write data, slice i = requester i
//   io_done    out  IO_COUNT             one-cycle completion pulse
//   io_err     out  IO_COUNT             one-cycle abort pulse
//   io_rdata   out  WORD_SIZE            read data, valid while io_done is high
//   mem_req    out  1                    memory request
//   mem_we     out  1                    1 = write
//   mem_addr   out  WORD_SIZE            physical address
//   mem_wdata  out  WORD_SIZE            write data
//   mem_ack    in   1                    memory completion
//   mem_rdata  in   WORD_SIZE            read data, valid with mem_ack
//
// Sequence: IDLE (pick + latch) -> ISSUE (mem_req up) -> WAIT (until ack)
//           -> DONE (io_done pulse) -> IDLE. Best case is 3 cycles req->done.
// -----------------------------------------------------------------------------
module io_mem_arbiter
    import gc::*;
#(
    parameter int TIMEOUT = IO_ARB_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IO_COUNT-1:0]           io_req,
    input  logic [IO_COUNT-1:0]           io_dir,
    input  logic [IO_COUNT*WORD_SIZE-1:0] io_addr,
    input  logic [IO_COUNT*WORD_SIZE-1:0] io_wdata,
    output logic [IO_COUNT-1:0]           io_done,
    output logic [IO_COUNT-1:0]           io_err,
    output logic [WORD_SIZE-1:0]          io_rdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [WORD_SIZE-1:0]          mem_addr,
    output logic [WORD_SIZE-1:0]          mem_wdata,
    input  logic                          mem_ack,
    input  logic [WORD_SIZE-1:0]          mem_rdata
);

    IO_ARB_STATE state, state_next;

    io_idx_t last_grant;
    io_idx_t winner;        // requester owning the current transaction
    io_idx_t pick_winner;
    logic    pick_valid;

    logic                 dir_q;
    // An ack that lands in ISSUE is remembered so WAIT can complete on it.
    logic                 ack_seen;
    logic [WORD_SIZE-1:0] ack_rdata;

    // Single-cycle strobes decoded from the FSM.
    logic latch_en;
    logic issue_ack;
    logic complete;
    logic abort;
    logic grant_done;

    io_rr_picker u_picker (
        .req        (io_req),
        .last_grant (last_grant),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

`ifdef IO_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    // True in the last permitted WAIT cycle; an ack in that cycle still wins.
    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: clocked state is always updated with non-blocking assignments so
    // every register samples the pre-edge values of its sources.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // ------------------------------------------------------------------
    // FSM next-state and strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        issue_ack  = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        grant_done = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    latch_en   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                issue_ack  = mem_ack;
                state_next = WAIT;
            end
            WAIT: begin
                if (ack_seen || mem_ack) begin
                    complete   = 1'b1;
                    state_next = DONE;
                end
`ifdef IO_ARB_TIMEOUT_EN
                else if (timed_out) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
`endif
            end
            DONE: begin
                grant_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            io_done    <= '0;
            io_rdata   <= '0;
            last_grant <= io_idx_t'(PS2_I);
            winner     <= io_idx_t'(VGA_I);
            dir_q      <= IO_OUT;
            ack_seen   <= 1'b0;
            ack_rdata  <= '0;
        end else begin
            io_done <= '0;

            if (latch_en) begin
                winner    <= pick_winner;
                dir_q     <= io_dir[pick_winner];
                mem_we    <= (io_dir[pick_winner] == IO_IN);
                mem_addr  <= io_phys_addr(pick_winner,
                                 io_addr[pick_winner*WORD_SIZE +: WORD_SIZE]);
                mem_wdata <= io_wdata[pick_winner*WORD_SIZE +: WORD_SIZE];
                mem_req   <= 1'b1;
                ack_seen  <= 1'b0;
            end

            // Memory already answered: withdraw the request right away so it
            // is not mistaken for a second access while WAIT finishes up.
            if (issue_ack) begin
                ack_seen  <= 1'b1;
                ack_rdata <= mem_rdata;
                mem_req   <= 1'b0;
            end

            if (complete) begin
                mem_req <= 1'b0;
                if (dir_q == IO_OUT)
                    io_rdata <= ack_seen ? ack_rdata : mem_rdata;
                io_done[winner] <= 1'b1;
            end

            if (abort)
                mem_req <= 1'b0;

            if (grant_done || abort)
                last_grant <= winner;
        end
    end

`ifdef IO_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            io_err   <= '0;
        end else begin
            io_err <= '0;
            if (state == ISSUE)
                wait_cnt <= '0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (abort)
                io_err[winner] <= 1'b1;
        end
    end
`else
    // Without the timeout option the parameter only documents the interface.
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT);
    assign io_err         = '0;
`endif

endmodule

// File: tb/tb_io_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_io_mem_arbiter: self-checking bench for io_mem_arbiter.
//
// The reference is a transaction timeline: when the arbiter is free and a
// request is seen in cycle k, mem_req is expected from k+1 until the ack cycle
// j; io_done follows at j+1 (or k+3 when the ack lands at k+1); the arbiter is
// free again the cycle after io_done. Every cycle the DUT outputs are compared
// against that timeline. A short directed prologue pins the model with
// hand-computed literals, then randomized requests, directions, addresses and
// ack delays run, with two resets injected mid-transaction.
// In an IO_ARB_TIMEOUT_EN build the DUT is given TIMEOUT=4 and some
// transactions are never acknowledged.
// -----------------------------------------------------------------------------
module tb_io_mem_arbiter;
    import gc::*;

    localparam int NCYC = 3000;
    localparam int TMO  = 4;
`ifdef IO_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                          clk = 1'b0;
    logic                          reset;
    logic [IO_COUNT-1:0]           io_req;
    logic [IO_COUNT-1:0]           io_dir;
    logic [IO_COUNT*WORD_SIZE-1:0] io_addr;
    logic [IO_COUNT*WORD_SIZE-1:0] io_wdata;
    logic [IO_COUNT-1:0]           io_done;
    logic [IO_COUNT-1:0]           io_err;
    logic [WORD_SIZE-1:0]          io_rdata;
    logic                          mem_req;
    logic                          mem_we;
    logic [WORD_SIZE-1:0]          mem_addr;
    logic [WORD_SIZE-1:0]          mem_wdata;
    logic                          mem_ack;
    logic [WORD_SIZE-1:0]          mem_rdata;

    io_mem_arbiter #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .io_req    (io_req),
        .io_dir    (io_dir),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_done   (io_done),
        .io_err    (io_err),
        .io_rdata  (io_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference timeline ----------------
    bit          busy;
    int          t_idx, t_win, t_start, t_ack, t_done, t_err, t_d;
    bit          t_we;
    logic [63:0] t_addr, t_wdata, t_rdata;
    int          m_last;
    logic [63:0] m_rdata;
    int          free_from;
    int          n_txn;
    int          rst_events;
    int          junk;
    bit          rst_chk;

    function automatic bit exp_mem_req(input int c);
        if (!busy || c < t_start + 1) return 1'b0;
        if (t_ack >= 0) return (c <= t_ack);
        if (t_err >= 0) return (c < t_err);
        return 1'b1;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [1:0]  oh;
        logic [1:0]  exp_done, exp_err;
        bit          mreq;
        int          w;
        int          r;

        reset     = 1'b1;
        io_req    = '0;
        io_dir    = '0;
        io_addr   = '0;
        io_wdata  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        busy = 1'b0; m_last = PS2_I; m_rdata = '0; free_from = 0;
        n_txn = 0; rst_events = 0; junk = 0; rst_chk = 1'b1;
        t_ack = -1; t_done = -1; t_err = -1; t_start = 0; t_d = 1;
        t_win = 0; t_idx = 0; t_we = 1'b0;
        t_addr = '0; t_wdata = '0; t_rdata = '0;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            cyc = c;

            // ---------------- compare ----------------
            mreq = exp_mem_req(c);
            if (rst_chk) begin
                check("rst_mem_addr", mem_addr, '0);
                check("rst_mem_we", {63'd0, mem_we}, 64'd0);
                check("rst_mem_wdata", mem_wdata, '0);
                rst_chk = 1'b0;
            end
            check("mem_req", {63'd0, mem_req}, {63'd0, mreq});
            if (mreq) begin
                check("mem_addr", mem_addr, t_addr);
                check("mem_we", {63'd0, mem_we}, {63'd0, t_we});
                check("mem_wdata", mem_wdata, t_wdata);
            end

            oh = '0;
            oh[t_win] = 1'b1;
            if (busy && c == t_done && !t_we) m_rdata = t_rdata;
            exp_done = (busy && c == t_done) ? oh : 2'b00;
            exp_err  = (busy && c == t_err)  ? oh : 2'b00;
            check("io_done", {62'd0, io_done}, {62'd0, exp_done});
            check("io_err", {62'd0, io_err}, {62'd0, exp_err});
            check("io_rdata", io_rdata, m_rdata);

            // hand-computed expectations for the directed prologue
            if (busy && c == t_start + 1) begin
                case (t_idx)
                    0: begin
                        check("lit_vga_addr", mem_addr, 64'h91);
                        check("lit_vga_we", {63'd0, mem_we}, 64'd0);
                    end
                    1: begin
                        check("lit_ps2_addr", mem_addr, 64'h0);
                        check("lit_ps2_we", {63'd0, mem_we}, 64'd1);
                        check("lit_ps2_wdata", mem_wdata, 64'h41);
                    end
                    4: check("lit_wrap_addr", mem_addr, 64'h80);
                    default: ;
                endcase
            end
            if (busy && c == t_done) begin
                case (t_idx)
                    0: begin
                        check("lit_rr0", {62'd0, io_done}, 64'h1);
                        check("lit_vga_rdata", io_rdata, 64'hDEAD);
                    end
                    1: begin
                        check("lit_rr1", {62'd0, io_done}, 64'h2);
                        check("lit_wr_keeps_rdata", io_rdata, 64'hDEAD);
                    end
                    2: check("lit_rr2", {62'd0, io_done}, 64'h1);
                    3: check("lit_rr3", {62'd0, io_done}, 64'h2);
                    default: ;
                endcase
            end

            if (busy && c == t_done) begin
                busy = 1'b0; m_last = t_win; free_from = c + 1;
            end
            if (busy && c == t_err) begin
                busy = 1'b0; m_last = t_win; free_from = c;
            end

            // ---------------- drive ----------------
            reset     = (c < 2);
            mem_ack   = 1'b0;
            mem_rdata = rand64();
            if (junk > 0) begin
                // stale acks after a reset must be ignored
                io_req  = '0;
                mem_ack = 1'b1;
                junk--;
            end else begin
                if (n_txn < 4) begin
                    io_req = 2'b11;
                    io_dir[VGA_I] = IO_OUT;
                    io_dir[PS2_I] = IO_IN;
                    io_addr[VGA_I*64 +: 64]  = 64'h10;
                    io_addr[PS2_I*64 +: 64]  = 64'h0;
                    io_wdata[VGA_I*64 +: 64] = 64'h0;
                    io_wdata[PS2_I*64 +: 64] = 64'h41;
                end else if (n_txn == 4) begin
                    io_req = 2'b01;
                    io_dir[VGA_I] = IO_OUT;
                    io_addr[VGA_I*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
                end else begin
                    io_req = 2'($urandom_range(0, 3));
                    io_dir = 2'($urandom_range(0, 3));
                    for (int i = 0; i < IO_COUNT; i++) begin
                        io_addr[i*64 +: 64] = ($urandom_range(0, 7) == 0)
                            ? (64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255)))
                            : rand64();
                        io_wdata[i*64 +: 64] = rand64();
                    end
                end
                if (mreq && c == t_start + t_d) begin
                    mem_ack = 1'b1;
                    if (n_txn <= 5) mem_rdata = 64'hDEAD;
                end
                if (c >= 2 && rst_events < 2 && n_txn >= 20 + 20 * rst_events &&
                    busy && t_ack < 0 && c == t_start + 2 && t_d >= 3) begin
                    reset   = 1'b1;
                    mem_ack = 1'b0;
                end
            end

            // ---------------- model update ----------------
            if (reset) begin
                busy = 1'b0; m_last = PS2_I; m_rdata = '0;
                free_from = c + 1; rst_chk = 1'b1;
                if (c >= 2) begin
                    rst_events++;
                    junk = 2;
                end
            end else begin
                if (busy && mreq && mem_ack && t_ack < 0) begin
                    t_ack   = c;
                    t_rdata = mem_rdata;
                    t_done  = (c == t_start + 1) ? c + 2 : c + 1;
                end else if (TMO_EN && busy && t_ack < 0 && t_err < 0 &&
                             c == t_start + 1 + TMO) begin
                    t_err = c + 1;
                end
                if (!busy && c >= free_from && io_req != '0) begin
                    if (io_req == 2'b11)
                        w = (m_last == VGA_I) ? PS2_I : VGA_I;
                    else
                        w = io_req[VGA_I] ? VGA_I : PS2_I;
                    t_win   = w;
                    t_we    = (io_dir[w] == IO_IN);
                    t_addr  = io_addr[w*64 +: 64] +
                              ((w == VGA_I) ? VGA_MEM_OFFSET : KEYBOARD_ADD);
                    t_wdata = io_wdata[w*64 +: 64];
                    t_start = c;
                    t_ack = -1; t_done = -1; t_err = -1;
                    t_idx = n_txn;
                    if (n_txn < 4) t_d = 3;
                    else if (n_txn == 4) t_d = 1;
                    else begin
                        r = $urandom_range(0, 7);
                        if (r <= 4)      t_d = 1 + (r % 3);
                        else if (r == 5) t_d = 1 + TMO;
                        else if (r == 6) t_d = TMO_EN ? 99 : 2;
                        else             t_d = 1;
                    end
                    n_txn++;
                    busy = 1'b1;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
